approx_adder_et_monitor: RTL and testbench

//  Parametrised pipelined approximate adder with a built-in error-threshold monitor.
//  - Approximation: lower-part OR (LOA) over APPROX_BITS LSBs; exact upper part.
//  - Each transaction computes the exact sum alongside the approximate one.
//  - Reports per-result absolute error and ET violation; keeps saturating statistics.
//  - Sits after generated approximate adders for in-circuit ET checking and error profiling.

---
 rtl/approx_adder_et_monitor.sv | 129 ++++++++++++
 tb/tb_approx_adder_et_monitor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_et_monitor.sv
// Two-stage LOA approximate adder with exact reference, error-threshold check and saturating statistics.
// Latency 2 cycles; S2 holds its result under out_ready=0 and in_ready drops once both stages are full.
module approx_adder_et_monitor #(
  parameter int WIDTH       = 4,
  parameter int APPROX_BITS = 2,
  parameter int ET          = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             approx_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [WIDTH:0]   out_err,
  output logic             out_viol,
  input  logic             stat_clear,
  output logic [CNT_W-1:0] stat_samples,
  output logic [CNT_W-1:0] stat_viols,
  output logic [WIDTH:0]   stat_max_err,
  output logic             et_alarm
);

  // LOW_MASK covers the OR-ed LSBs; C_MASK picks bit K-1, the carry source into the exact part.
  localparam logic [WIDTH:0] LOW_MASK = {(WIDTH+1){1'b1}} >> (WIDTH + 1 - APPROX_BITS);
  localparam logic [WIDTH:0] C_MASK   = LOW_MASK ^ (LOW_MASK >> 1);
  localparam logic [31:0]    ET_U     = 32'(ET);

  logic             s1_vld_q, s1_apx_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic             s2_vld_q, viol_q;
  logic [WIDTH:0]   sum_q, err_q;
  logic             s1_load, s2_load, xfer;

  logic [WIDTH:0]   a_x, b_x, exact, high, approx, sum_d, err_d;
  logic             carry, viol_d;

  logic [CNT_W-1:0] samples_q, samples_d, viols_q, viols_d;
  logic [WIDTH:0]   max_q, max_d;
  logic             alarm_q, alarm_d;

  assign s2_load  = !s2_vld_q || out_ready;
  assign s1_load  = !s1_vld_q || s2_load;
  assign in_ready = s1_load;
  assign xfer     = s2_vld_q && out_ready;

  always_comb begin
    a_x    = {1'b0, s1_a_q};
    b_x    = {1'b0, s1_b_q};
    exact  = a_x + b_x;
    carry  = |(a_x & b_x & C_MASK);
    high   = (a_x >> APPROX_BITS) + (b_x >> APPROX_BITS) + {{WIDTH{1'b0}}, carry};
    approx = (high << APPROX_BITS) | ((a_x | b_x) & LOW_MASK);
    sum_d  = s1_apx_q ? approx : exact;
    err_d  = (sum_d >= exact) ? (sum_d - exact) : (exact - sum_d);
    viol_d = 32'(err_d) > ET_U;
  end

  // Clear takes priority over a coincident output transfer.
  always_comb begin
    samples_d = samples_q;
    viols_d   = viols_q;
    max_d     = max_q;
    alarm_d   = alarm_q;
    if (stat_clear) begin
      samples_d = '0;
      viols_d   = '0;
      max_d     = '0;
      alarm_d   = 1'b0;
    end else if (xfer) begin
      if (samples_q != '1) samples_d = samples_q + CNT_W'(1);
      if (viol_q && (viols_q != '1)) viols_d = viols_q + CNT_W'(1);
      if (err_q > max_q) max_d = err_q;
      alarm_d = alarm_q | viol_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_apx_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s2_vld_q  <= 1'b0;
      sum_q     <= '0;
      err_q     <= '0;
      viol_q    <= 1'b0;
      samples_q <= '0;
      viols_q   <= '0;
      max_q     <= '0;
      alarm_q   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_vld_q <= in_valid;
        if (in_valid) begin
          s1_a_q   <= in0;
          s1_b_q   <= in1;
          s1_apx_q <= approx_en;
        end
      end
      if (s2_load) begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          sum_q  <= sum_d;
          err_q  <= err_d;
          viol_q <= viol_d;
        end
      end
      samples_q <= samples_d;
      viols_q   <= viols_d;
      max_q     <= max_d;
      alarm_q   <= alarm_d;
    end
  end

  assign out_valid    = s2_vld_q;
  assign out_sum      = sum_q;
  assign out_err      = err_q;
  assign out_viol     = viol_q;
  assign stat_samples = samples_q;
  assign stat_viols   = viols_q;
  assign stat_max_err = max_q;
  assign et_alarm     = alarm_q;

endmodule

// File: tb/tb_approx_adder_et_monitor.sv
// Directed bench: main build (W=4,K=2,ET=1), a CNT_W=3 build for saturation, and an exact (K=0) build.
module tb_approx_adder_et_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       approx_en = 1'b0, in_valid = 1'b0, out_ready = 1'b0, stat_clear = 1'b0;
  logic [3:0] in0 = '0, in1 = '0;

  logic        d_in_ready, d_out_valid, d_out_viol, d_alarm;
  logic [4:0]  d_sum, d_err, d_max;
  logic [15:0] d_samples, d_viols;

  logic        s_in_ready, s_out_valid, s_out_viol, s_alarm;
  logic [4:0]  s_sum, s_err, s_max;
  logic [2:0]  s_samples, s_viols;

  logic        e_in_ready, e_out_valid, e_out_viol, e_alarm;
  logic [4:0]  e_sum, e_err, e_max;
  logic [15:0] e_samples, e_viols;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  approx_adder_et_monitor #(.WIDTH(4), .APPROX_BITS(2), .ET(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .approx_en(approx_en), .in_valid(in_valid), .in_ready(d_in_ready),
    .in0(in0), .in1(in1), .out_valid(d_out_valid), .out_ready(out_ready), .out_sum(d_sum),
    .out_err(d_err), .out_viol(d_out_viol), .stat_clear(stat_clear), .stat_samples(d_samples),
    .stat_viols(d_viols), .stat_max_err(d_max), .et_alarm(d_alarm));

  approx_adder_et_monitor #(.WIDTH(4), .APPROX_BITS(2), .ET(1), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .approx_en(approx_en), .in_valid(in_valid), .in_ready(s_in_ready),
    .in0(in0), .in1(in1), .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_sum),
    .out_err(s_err), .out_viol(s_out_viol), .stat_clear(stat_clear), .stat_samples(s_samples),
    .stat_viols(s_viols), .stat_max_err(s_max), .et_alarm(s_alarm));

  approx_adder_et_monitor #(.WIDTH(4), .APPROX_BITS(0), .ET(1), .CNT_W(16)) u_exact (
    .clk(clk), .rst(rst), .approx_en(approx_en), .in_valid(in_valid), .in_ready(e_in_ready),
    .in0(in0), .in1(in1), .out_valid(e_out_valid), .out_ready(out_ready), .out_sum(e_sum),
    .out_err(e_err), .out_viol(e_out_viol), .stat_clear(stat_clear), .stat_samples(e_samples),
    .stat_viols(e_viols), .stat_max_err(e_max), .et_alarm(e_alarm));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic en);
    in_valid  = v;
    in0       = a;
    in1       = b;
    approx_en = en;
  endtask

  // Hand-computed LOA (K=2) results for the stall stream.
  int t_a[8]    = '{1, 5, 7, 9, 10, 15, 12, 6};
  int t_b[8]    = '{2, 6, 7, 4, 10, 1, 12, 3};
  int t_sum[8]  = '{3, 11, 15, 13, 22, 15, 24, 11};
  int t_err[8]  = '{0, 0, 1, 0, 2, 1, 0, 2};
  int t_viol[8] = '{0, 0, 0, 0, 1, 0, 0, 1};

  initial begin
    int acc;
    int oidx;
    int a_r;
    int b_r;
    logic [4:0] exp_q[$];
    logic [4:0] exp_s;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", d_out_valid, 0);
    check("rst_samples", d_samples, 0);
    check("rst_viols", d_viols, 0);
    check("rst_max", d_max, 0);
    check("rst_alarm", d_alarm, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", d_in_ready, 1);

    // Basic approximate / exact results and first violation
    drive(1, 4'd3, 4'd1, 1);
    @(negedge clk); drive(1, 4'd3, 4'd3, 1);
    @(negedge clk);
    check("t2_valid", d_out_valid, 1);
    check("t2_sum_3p1", d_sum, 3);
    check("t2_err_3p1", d_err, 1);
    check("t2_viol_3p1", d_out_viol, 0);
    drive(1, 4'd2, 4'd2, 1);
    @(negedge clk);
    check("t2_sum_3p3", d_sum, 7);
    check("t2_err_3p3", d_err, 1);
    check("t2_samples1", d_samples, 1);
    drive(1, 4'd15, 4'd15, 0);
    @(negedge clk);
    check("t3_sum_2p2", d_sum, 6);
    check("t3_err_2p2", d_err, 2);
    check("t3_viol_2p2", d_out_viol, 1);
    check("t3_alarm_before_accept", d_alarm, 0);
    drive(0, 4'd0, 4'd0, 0);
    @(negedge clk);
    check("t4_sum_bypass", d_sum, 30);
    check("t4_err_bypass", d_err, 0);
    check("t4_viol_bypass", d_out_viol, 0);
    check("t3_alarm", d_alarm, 1);
    check("t3_viols", d_viols, 1);
    check("t3_max", d_max, 2);
    check("t3_samples", d_samples, 3);
    @(negedge clk);
    check("t3_drained", d_out_valid, 0);
    check("t3_samples_end", d_samples, 4);

    // Asynchronous reset with results in flight
    out_ready = 1'b0;
    drive(1, 4'd2, 4'd2, 1);
    @(negedge clk); drive(1, 4'd1, 4'd1, 1);
    @(negedge clk); drive(0, 4'd0, 4'd0, 0);
    @(negedge clk);
    check("t1_pre_valid", d_out_valid, 1);
    rst = 1'b1;
    #1;
    check("t1_async_valid", d_out_valid, 0);
    check("t1_async_samples", d_samples, 0);
    check("t1_async_viols", d_viols, 0);
    check("t1_async_max", d_max, 0);
    check("t1_async_alarm", d_alarm, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t1_in_ready_release", d_in_ready, 1);
    check("t1_no_ghost", d_out_valid, 0);

    // Stream of 8 with out_ready low for the first 5 cycles
    acc = 0;
    oidx = 0;
    for (int cyc = 0; cyc < 60 && oidx < 8; cyc++) begin
      @(negedge clk);
      if (d_out_valid) begin
        check("t5_in_order_range", oidx < 8, 1);
        if (oidx < 8) begin
          check("t5_sum", d_sum, t_sum[oidx]);
          check("t5_err", d_err, t_err[oidx]);
          check("t5_viol", d_out_viol, t_viol[oidx]);
        end
      end
      out_ready = (cyc >= 5);
      if (acc < 8) drive(1, 4'(t_a[acc]), 4'(t_b[acc]), 1);
      else drive(0, 4'd0, 4'd0, 0);
      #1;
      if (d_out_valid && out_ready) oidx++;
      if (in_valid && d_in_ready) acc++;
      if (cyc == 4) begin
        check("t5_accepts_in_stall", acc, 2);
        check("t5_in_ready_stall", d_in_ready, 0);
      end
    end
    check("t5_all_results", oidx, 8);
    @(negedge clk);
    drive(0, 4'd0, 4'd0, 0);
    @(negedge clk);
    check("t5_samples", d_samples, 8);
    check("t5_viols", d_viols, 2);
    check("t5_max", d_max, 2);
    check("t5_alarm", d_alarm, 1);
    check("t5_sat_samples", s_samples, 7);

    // stat_clear coincident with an output transfer
    @(negedge clk); drive(1, 4'd2, 4'd2, 1);
    @(negedge clk); drive(0, 4'd0, 4'd0, 0);
    @(negedge clk);
    check("t6_pre_valid", d_out_valid, 1);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    check("t6_clr_samples", d_samples, 0);
    check("t6_clr_viols", d_viols, 0);
    check("t6_clr_max", d_max, 0);
    check("t6_clr_alarm", d_alarm, 0);
    check("t6_clr_sat_samples", s_samples, 0);

    // Nine violating results saturate the 3-bit counters
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      drive(1, 4'd2, 4'd2, 1);
    end
    @(negedge clk); drive(0, 4'd0, 4'd0, 0);
    repeat (4) @(negedge clk);
    check("t6_sat_viols", s_viols, 7);
    check("t6_sat_samples", s_samples, 7);
    check("t6_viols", d_viols, 9);
    check("t6_samples", d_samples, 9);
    check("t6_alarm", d_alarm, 1);

    // Exact build: random operands never produce error
    for (int k = 0; k < 1004; k++) begin
      @(negedge clk);
      if (e_out_valid) begin
        check("t4r_have_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_s = exp_q.pop_front();
          check("t4r_sum", e_sum, exp_s);
          check("t4r_err", e_err, 0);
        end
      end
      if (k < 1000) begin
        a_r = $urandom_range(0, 15);
        b_r = $urandom_range(0, 15);
        drive(1, 4'(a_r), 4'(b_r), 1'($urandom_range(0, 1)));
        exp_q.push_back(5'(a_r + b_r));
      end else begin
        drive(0, 4'd0, 4'd0, 0);
      end
    end
    check("t4r_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
